// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: fetch-stage reset defaults, PC increment and IF state encoding.
package mycpu_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry capture/replay buffer keeping the presented instruction alive across a stall.
module if_hold_buf
    import mycpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_i,
    input  logic            release_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] hold_inst_o,
    output logic            hold_vld_o
);

    logic [XLEN-1:0] hold_inst_d, hold_inst_q;
    logic            hold_vld_d, hold_vld_q;

    // Kill and release both empty the entry; capture only matters when neither applies.
    always_comb begin
        hold_inst_d = hold_inst_q;
        hold_vld_d  = hold_vld_q;
        if (kill_i || release_i) begin
            hold_vld_d = 1'b0;
        end else if (capture_i) begin
            hold_inst_d = data_i;
            hold_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst_q <= NOP_INST;
            hold_vld_q  <= 1'b0;
        end else begin
            hold_inst_q <= hold_inst_d;
            hold_vld_q  <= hold_vld_d;
        end
    end

    assign hold_inst_o = hold_inst_q;
    assign hold_vld_o  = hold_vld_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle sync SRAM, handles stalls and redirects.
// Optional IF_ADEF_EN: misaligned fetch yields one NOP slot flagged on if_adef_o, then halts.
module if_fetch_stage
    import mycpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pipeline_stop_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            inst_sram_en_o,
    output logic [XLEN-1:0] inst_sram_addr_o,
    input  logic [XLEN-1:0] inst_sram_rdata_i,
    output logic [XLEN-1:0] if_pc4_o,
    output logic [XLEN-1:0] if_inst_o,
    output logic            if_debug_wb_have_inst
`ifdef IF_ADEF_EN
    ,
    output logic            if_adef_o
`endif
);

`ifdef IF_ADEF_EN
    localparam bit ADEF_EN = 1'b1;
`else
    localparam bit ADEF_EN = 1'b0;
`endif

    if_state_t       state_d, state_q;
    logic [XLEN-1:0] req_pc_d, req_pc_q;
    logic [XLEN-1:0] rsp_pc_d, rsp_pc_q;
    logic            rsp_vld_d, rsp_vld_q;
    logic            adef_d, adef_q;
    logic            halt_d, halt_q;

    logic            stall;
    logic            redirect;
    logic            advance;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic            hold_capture, hold_release, hold_kill;
    logic [XLEN-1:0] hold_inst;
    logic            hold_vld;
    logic [XLEN-1:0] capture_data;

    assign stall    = |pipeline_stop_i;
    assign redirect = branch_taken_i && (state_q != IDLE);
    assign advance  = (state_q != IDLE) && !stall && !branch_taken_i;
    assign misalign = ADEF_EN && (|req_pc_q[1:0]);
    assign target   = ADEF_EN ? branch_target_i : (branch_target_i & ~XLEN'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (branch_taken_i)        state_d = RUN;
                else if (stall && rsp_vld_q) state_d = HOLD;
            end
            HOLD: begin
                if (branch_taken_i || !stall) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request enable, PC/response bookkeeping and hold-buffer control.
    always_comb begin
        inst_sram_en_o = advance && !misalign;
        req_pc_d       = req_pc_q;
        rsp_pc_d       = rsp_pc_q;
        rsp_vld_d      = rsp_vld_q;
        adef_d         = adef_q;
        halt_d         = halt_q;
        hold_capture   = 1'b0;
        hold_release   = 1'b0;
        hold_kill      = 1'b0;
        if (redirect) begin
            rsp_vld_d = 1'b0;
            adef_d    = 1'b0;
            halt_d    = 1'b0;
            hold_kill = 1'b1;
            req_pc_d  = target;
        end else if (advance) begin
            hold_release = (state_q == HOLD);
            if (misalign) begin
                // A misaligned PC produces a single flagged slot, then fetch parks.
                rsp_vld_d = !halt_q;
                adef_d    = !halt_q;
                halt_d    = 1'b1;
                if (!halt_q) rsp_pc_d = req_pc_q;
            end else begin
                rsp_pc_d  = req_pc_q;
                rsp_vld_d = 1'b1;
                adef_d    = 1'b0;
                req_pc_d  = req_pc_q + PC_INC;
            end
        end else if ((state_q == RUN) && stall && rsp_vld_q) begin
            hold_capture = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q  <= RESET_PC;
            rsp_pc_q  <= '0;
            rsp_vld_q <= 1'b0;
            adef_q    <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            req_pc_q  <= req_pc_d;
            rsp_pc_q  <= rsp_pc_d;
            rsp_vld_q <= rsp_vld_d;
            adef_q    <= adef_d;
            halt_q    <= halt_d;
        end
    end

    assign capture_data = adef_q ? NOP_INST : inst_sram_rdata_i;

    if_hold_buf #(
        .NOP_INST (NOP_INST)
    ) u_hold_buf (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (hold_capture),
        .release_i   (hold_release),
        .kill_i      (hold_kill),
        .data_i      (capture_data),
        .hold_inst_o (hold_inst),
        .hold_vld_o  (hold_vld)
    );

    assign inst_sram_addr_o      = req_pc_q;
    assign if_pc4_o              = rsp_pc_q + PC_INC;
    assign if_inst_o             = hold_vld ? hold_inst
                                 : ((rsp_vld_q && !adef_q) ? inst_sram_rdata_i : NOP_INST);
    assign if_debug_wb_have_inst = rsp_vld_q && !branch_taken_i;
`ifdef IF_ADEF_EN
    assign if_adef_o             = rsp_vld_q && adef_q && !branch_taken_i;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a synchronous instruction SRAM with 1-cycle read latency.
- Presents {pc+4, instruction, valid} to IF/ID, and handles pipeline stalls and branch redirects without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'hbfc0_0000, address of the first fetch after reset.
- NOP_INST, 32'h0000_0000, instruction value driven when no valid instruction is presented.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pipeline_stop_i  in  2  stall request; any nonzero value means stall.
- branch_taken_i  in  1  redirect request from ID.
- branch_target_i  in  32  redirect address.
- inst_sram_en_o  out  1  SRAM read enable.
- inst_sram_addr_o  out  32  SRAM read address.
- inst_sram_rdata_i  in  32  SRAM data; valid the cycle after en=1.
- if_pc4_o  out  32  pc+4 of the presented instruction.
- if_inst_o  out  32  presented instruction.
- if_debug_wb_have_inst  out  1  presented slot holds a real instruction.

Behaviour:
- Registers:
  - req_pc: next address to request.
  - rsp_pc, rsp_vld: request issued last cycle.
  - hold_inst, hold_vld: instruction captured while stalled.
- Reset, while rst=1 at the clock edge:
  - state<=IDLE, req_pc<=RESET_PC, rsp_pc<=0, rsp_vld<=0, hold_vld<=0, hold_inst<=NOP_INST.
- Combinational outputs:
  - inst_sram_addr_o = req_pc.
  - inst_sram_en_o = (state!=IDLE) && !stall && !branch_taken_i, where stall = |pipeline_stop_i.
- Presented slot:
  - if_inst_o = hold_vld ? hold_inst : (rsp_vld ? inst_sram_rdata_i : NOP_INST).
  - if_pc4_o = rsp_pc + 32'd4, modulo 2^32.
  - if_debug_wb_have_inst = rsp_vld && !branch_taken_i.
- States: IDLE, RUN, HOLD.
  - IDLE: no request issued. Next state is RUN unconditionally. First request goes to RESET_PC the cycle after reset deasserts; first valid slot one cycle later.
  - RUN, no stall, no redirect:
    - Issue req_pc.
    - rsp_pc<=req_pc, rsp_vld<=1, req_pc<=req_pc+4.
  - RUN, stall, rsp_vld=1:
    - hold_inst<=inst_sram_rdata_i, hold_vld<=1.
    - req_pc, rsp_pc and rsp_vld unchanged; go to HOLD.
  - RUN, stall, rsp_vld=0: no request, no state change.
  - HOLD, stall: everything frozen; slot re-presented from hold_inst every cycle.
  - HOLD, stall released:
    - Present hold_inst and issue req_pc.
    - rsp_pc<=req_pc, rsp_vld<=1, req_pc<=req_pc+4, hold_vld<=0; go to RUN.
  - Stall delays a slot but never drops or duplicates it.
- Redirect, any state except IDLE, regardless of stall:
  - The slot presented this cycle is killed (valid output 0 combinationally).
  - rsp_vld<=0, hold_vld<=0, req_pc<=branch_target_i; go to RUN.
  - No request is issued this cycle. The target is issued on the first following cycle without stall. There is no delay slot.
- Redirect and stall in the same cycle: redirect wins for PC and kill; the stall only postpones issuing the target.
- Back-to-back redirects: the last one wins.
- Reset mid-stall or mid-redirect: the reset values above apply unconditionally.
- Alignment: without the optional feature, target bits [1:0] are forced to 0 when loaded into req_pc.

Optional Feature:
- Macro: IF_ADEF_EN.
- When defined:
  - Adds output if_adef_o (1 bit).
  - req_pc[1:0] is kept unmasked.
  - A misaligned req_pc issues no SRAM request but still produces a slot: rsp_vld<=1 plus a registered adef flag. That slot presents NOP_INST with if_adef_o=1.
  - Fetch then halts (en=0, req_pc held) until the next redirect.
- When undefined: port absent, bits [1:0] masked to 0, no halt.

Decomposition:
- Shared package mycpu_pkg holds:
  - RESET_PC and NOP_INST defaults.
  - if_state_t enum {IDLE, RUN, HOLD}.
  - PC_INC constant 32'd4.
- One natural sub-module, if_hold_buf: a 1-entry capture/replay buffer holding hold_inst and hold_vld, with capture, release and kill inputs.
- PC logic stays in the top.

Test Plan:
- Reset release, no stall; ROM returns addr as data:
  - First request at 0xbfc00000.
  - Slots (pc4, inst) = (0xbfc00004, 0xbfc00000), (0xbfc00008, 0xbfc00004), … in consecutive cycles with valid=1.
- pipeline_stop_i=2'b01 for 3 cycles while slot pc4=0xbfc00008 is presented:
  - Same inst held for 4 cycles; en=0 during the stall.
  - Next slot has pc4 0xbfc0000c; no gaps or duplicates after release.
- branch_taken_i=1 with target 0xbfc00100 (no stall):
  - Current slot valid=0.
  - Next request at 0xbfc00100; its slot has pc4 0xbfc00104.
- Redirect to 0xbfc00200 during a 2-cycle stall:
  - Held slot killed; no request while stalled.
  - First request after release at 0xbfc00200.
- rst=1 asserted mid-HOLD:
  - Next cycle valid=0, en=0, addr=0xbfc00000.
  - Normal restart after deassert.
- With IF_ADEF_EN, redirect to 0xbfc00102:
  - One slot with if_adef_o=1, inst=0, no SRAM request.
  - Fetch halts until a redirect to 0xbfc00300 resumes it.
